conv_window_stream: RTL and testbench

- Parametrised successor to the fixed 3-row convolution FIFO. Streams row-major pixels in and emits complete KxK windows out, with valid/ready handshakes on both sides.
- Adds configurable stride, per-frame row/column lengths, backpressure and frame-done signalling.
- Sits between the pixel DMA/input stage and the MAC array of the CNN datapath.

---
 rtl/conv_window_stream.sv | 124 ++++++++++++
 tb/tb_conv_window_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_stream.sv
// conv_window_stream: streams row-major pixels into K-1 line buffers and emits KxK windows with valid/ready.
// Optional CONV_WIN_COORD_EN adds win_x/win_y, the top-left input coordinates of each window.
module conv_window_stream #(
   parameter int WIDTH    = 8,
   parameter int ADDR_BIT = 5,
   parameter int K        = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_BIT:0]       row_len,
   input  logic [ADDR_BIT:0]       col_len,
   input  logic [1:0]              stride,
   input  logic [WIDTH-1:0]        in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [K*K*WIDTH-1:0]    win,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    cfg_err
`ifdef CONV_WIN_COORD_EN
   ,
   output logic [ADDR_BIT:0]       win_x,
   output logic [ADDR_BIT:0]       win_y
`endif
);
   localparam int DEPTH = 1 << ADDR_BIT;
   localparam logic [ADDR_BIT:0] ONE = 1;
   localparam logic [ADDR_BIT:0] KM1 = (ADDR_BIT+1)'(K-1);
   localparam logic [ADDR_BIT:0] KMIN = (ADDR_BIT+1)'(K);
   localparam logic [ADDR_BIT:0] KMAX = (ADDR_BIT+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
   state_t state, state_nxt;
   logic [ADDR_BIT:0] row_len_r, col_len_r, x, y;
   logic [1:0] stride_r, sx, sy;
   logic [WIDTH-1:0] lb [K-1][DEPTH];
   logic [WIDTH-1:0] col [K];
   logic [K*K*WIDTH-1:0] win_nxt;
   logic cfg_ok, acc, x_end, last, col_hit, row_hit, go;
   assign cfg_ok = row_len >= KMIN && row_len <= KMAX && col_len >= KMIN && col_len <= KMAX && stride != 2'd0;
   assign acc = in_valid && in_ready;
   assign go = !win_valid || win_ready;
   assign x_end = x + ONE == row_len_r;
   assign last = x_end && y + ONE == col_len_r;
   // stride phase: sx/sy count down to the next window column/row once past the K-1 margin
   assign col_hit = x == KM1 || (x > KM1 && sx == 2'd0);
   assign row_hit = y == KM1 || (y > KM1 && sy == 2'd0);
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = (state == IDLE && start && cfg_ok) ? ACTIVE :
                  (state == ACTIVE && acc && last)   ? DRAIN  :
                  (state == DRAIN && go)             ? IDLE   : state;
   end
   always_comb begin
      in_ready = state == ACTIVE && go;
      busy = state != IDLE;
      frame_done = state == DRAIN && go;
   end
   always_ff @(posedge clk)
      if (rst) begin
         cfg_err <= 1'b0;
         row_len_r <= '0;
         col_len_r <= '0;
         stride_r <= '0;
      end else if (state == IDLE && start) begin
         cfg_err <= !cfg_ok;
         row_len_r <= row_len;
         col_len_r <= col_len;
         stride_r <= stride;
      end
   always_ff @(posedge clk)
      if (rst || state == IDLE) begin
         x <= '0;
         y <= '0;
         sx <= '0;
         sy <= '0;
      end else if (acc) begin
         x <= x_end ? '0 : x + ONE;
         sx <= col_hit ? stride_r - 2'd1 : sx - 2'd1;
         if (x_end) begin
            y <= y + ONE;
            sy <= row_hit ? stride_r - 2'd1 : sy - 2'd1;
         end
      end
   // line-buffer RAM: cascade shifts column x of each stored row down by one row
   always_ff @(posedge clk)
      if (acc) begin
         lb[0][x[ADDR_BIT-1:0]] <= in;
         for (int i = 1; i < K-1; i++) lb[i][x[ADDR_BIT-1:0]] <= lb[i-1][x[ADDR_BIT-1:0]];
      end
   always_comb begin
      col[K-1] = in;
      for (int r = 0; r < K-1; r++) col[r] = lb[K-2-r][x[ADDR_BIT-1:0]];
   end
   always_comb begin
      win_nxt = win;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K-1; c++) win_nxt[(r*K+c)*WIDTH +: WIDTH] = win[(r*K+c+1)*WIDTH +: WIDTH];
         win_nxt[(r*K+K-1)*WIDTH +: WIDTH] = col[r];
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         win <= '0;
         win_valid <= 1'b0;
      end else if (acc) begin
         win <= win_nxt;
         win_valid <= col_hit && row_hit;
      end else if (win_ready) win_valid <= 1'b0;
`ifdef CONV_WIN_COORD_EN
   always_ff @(posedge clk)
      if (rst) begin
         win_x <= '0;
         win_y <= '0;
      end else if (acc && col_hit && row_hit) begin
         win_x <= x - KM1;
         win_y <= y - KM1;
      end
`endif
endmodule

// File: tb/tb_conv_window_stream.sv
// tb_conv_window_stream: random and directed frames checked every cycle against a frame-array window model.
module tb_conv_window_stream;
  localparam int WIDTH = 8, ADDR_BIT = 5, K = 3, WW = K*K*WIDTH;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, win_ready = 1'b0;
  logic [ADDR_BIT:0] row_len = '0, col_len = '0;
  logic [1:0] stride = '0;
  logic [WIDTH-1:0] in = '0;
  logic in_ready, win_valid, busy, frame_done, cfg_err;
  logic [WW-1:0] win;
`ifdef CONV_WIN_COORD_EN
  logic [ADDR_BIT:0] win_x, win_y;
`endif
  conv_window_stream #(.WIDTH(WIDTH), .ADDR_BIT(ADDR_BIT), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .col_len(col_len), .stride(stride),
    .in(in), .in_valid(in_valid), .in_ready(in_ready), .win(win), .win_valid(win_valid),
    .win_ready(win_ready), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
`ifdef CONV_WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  typedef enum {M_IDLE, M_ACT, M_DRAIN} mstate_t;
  mstate_t ms = M_IDLE;
  logic mon_on = 1'b0, m_err = 1'b0, m_valid = 1'b0, acc_seen = 1'b0;
  logic [WW-1:0] m_win = '0;
  int m_wx = 0, m_wy = 0, m_rl = 0, m_cl = 0, m_st = 1, m_n = 0;
  logic [WIDTH-1:0] pix [32][32];
  int n_xfer = 0, n_done = 0, first_valid_acc = -1;
  logic [WW-1:0] got_q[$];
  function automatic logic [WW-1:0] window_at(input int y0, input int x0);
    logic [WW-1:0] w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) w[(r*K+c)*WIDTH +: WIDTH] = pix[y0+r][x0+c];
    return w;
  endfunction
  function automatic logic [WW-1:0] pack(input int e[9]);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < 9; i++) w[i*WIDTH +: WIDTH] = WIDTH'(e[i]);
    return w;
  endfunction
  always @(negedge clk) begin
    int yy, xx;
    logic go, hit;
    acc_seen = in_valid && in_ready;
    if (mon_on) begin
      go = !m_valid || win_ready;
      chk("win_valid", win_valid, m_valid);
      if (m_valid) chk("win", win, m_win);
`ifdef CONV_WIN_COORD_EN
      if (m_valid) begin
        chk("win_x", int'(win_x), m_wx);
        chk("win_y", int'(win_y), m_wy);
      end
`endif
      chk("in_ready", in_ready, ms == M_ACT && go);
      chk("busy", busy, ms != M_IDLE);
      chk("frame_done", frame_done, ms == M_DRAIN && go);
      chk("cfg_err", cfg_err, m_err);
      if (win_valid && win_ready) begin
        n_xfer++;
        got_q.push_back(win);
      end
      if (win_valid && first_valid_acc < 0) first_valid_acc = m_n;
      if (frame_done) n_done++;
      if (rst) begin
        ms = M_IDLE;
        m_valid = 1'b0;
        m_err = 1'b0;
      end else if (ms == M_IDLE) begin
        if (start) begin
          if (int'(row_len) >= K && int'(row_len) <= 32 && int'(col_len) >= K && int'(col_len) <= 32 && stride != 0) begin
            ms = M_ACT;
            m_err = 1'b0;
            m_rl = int'(row_len);
            m_cl = int'(col_len);
            m_st = int'(stride);
            m_n = 0;
          end else m_err = 1'b1;
        end
      end else if (ms == M_ACT) begin
        if (acc_seen) begin
          yy = m_n / m_rl;
          xx = m_n % m_rl;
          pix[yy][xx] = in;
          m_n++;
          hit = yy >= K-1 && xx >= K-1 && (yy-(K-1)) % m_st == 0 && (xx-(K-1)) % m_st == 0;
          m_valid = hit;
          if (hit) begin
            m_win = window_at(yy-(K-1), xx-(K-1));
            m_wx = xx-(K-1);
            m_wy = yy-(K-1);
          end
          if (m_n == m_rl*m_cl) ms = M_DRAIN;
        end else if (win_ready) m_valid = 1'b0;
      end else if (go) begin
        ms = M_IDLE;
        m_valid = 1'b0;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input int rl, input int cl, input int st, input logic seq, input int vp, input int rp,
                           input logic stall, input int abort_at);
    int p = 0, budget = 0, stall_left = 0, exp_n;
    logic stalled = 1'b0;
    row_len = (ADDR_BIT+1)'(rl);
    col_len = (ADDR_BIT+1)'(cl);
    stride = 2'(st);
    n_xfer = 0;
    n_done = 0;
    first_valid_acc = -1;
    got_q.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    in = seq ? WIDTH'(p) : WIDTH'($urandom);
    while (ms != M_IDLE && budget < 20000) begin
      if (abort_at >= 0 && p == abort_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        tick;
        rst = 1'b0;
        return;
      end
      if (stall && !stalled && win_valid) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      win_ready = stall_left > 0 ? 1'b0 : $urandom_range(99) < rp;
      if (stall_left > 0) stall_left--;
      in_valid = p < rl*cl && $urandom_range(99) < vp;
      tick;
      budget++;
      if (acc_seen) begin
        p++;
        in = seq ? WIDTH'(p) : WIDTH'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("frame_timeout", budget < 20000, 1'b1);
    exp_n = ((rl-K)/st+1) * ((cl-K)/st+1);
    chk("win_count", n_xfer, exp_n);
    chk("frame_done_pulses", n_done, 1);
    chk("busy_after_frame", busy, 1'b0);
  endtask
  task automatic check_scenario1;
    int e[9];
    chk("first_valid_after_pixel18", first_valid_acc, 19);
    e = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    chk("first_window", got_q.size() > 0 ? got_q[0] : '0, pack(e));
    e = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
    chk("last_window", got_q.size() > 35 ? got_q[35] : '0, pack(e));
  endtask
  initial begin
    int e[9];
    logic [WW-1:0] w4;
    repeat (3) tick;
    chk("rst_win", win, '0);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    mon_on = 1'b1;
    rst = 1'b0;
    tick;
    run_frame(8, 8, 1, 1'b1, 100, 100, 1'b0, -1);
    check_scenario1();
    run_frame(8, 8, 2, 1'b1, 100, 100, 1'b0, -1);
    e = '{2, 3, 4, 10, 11, 12, 18, 19, 20};
    chk("stride2_second_window", got_q.size() > 1 ? got_q[1] : '0, pack(e));
    w4 = got_q.size() > 3 ? got_q[3] : '0;
    chk("stride2_fourth_topleft", w4[WIDTH-1:0], WIDTH'(16));
    run_frame(8, 8, 1, 1'b1, 100, 100, 1'b1, -1);
    check_scenario1();
    row_len = 6'd2;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("cfg_err_short_row", cfg_err, 1'b1);
    chk("cfg_err_busy", busy, 1'b0);
    chk("cfg_err_in_ready", in_ready, 1'b0);
    tick;
    row_len = 6'd8;
    col_len = 6'd33;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("cfg_err_long_col", cfg_err, 1'b1);
    col_len = 6'd8;
    stride = 2'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("cfg_err_stride0", cfg_err, 1'b1);
    run_frame(8, 8, 1, 1'b1, 100, 100, 1'b0, -1);
    chk("cfg_err_cleared", cfg_err, 1'b0);
    run_frame(8, 8, 1, 1'b1, 100, 100, 1'b0, 30);
    chk("abort_win", win, '0);
    chk("abort_win_valid", win_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_frame_done", n_done, 0);
    tick;
    run_frame(8, 8, 1, 1'b1, 100, 100, 1'b0, -1);
    check_scenario1();
    run_frame(32, 3, 3, 1'b0, 100, 100, 1'b0, -1);
    repeat (6) begin
      tick;
      run_frame($urandom_range(32, 3), $urandom_range(10, 3), $urandom_range(3, 1), 1'b0,
                $urandom_range(100, 40), $urandom_range(100, 30), 1'b0, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
